// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - two-requester arbiter in front of the start/done memory bus
// Requests are captured per port, one is granted per bus transaction, and an optional watchdog forces completion.
module bus_arbiter #(
  parameter int PRIORITY = 0,
  parameter int TIMEOUT  = 0,
  parameter int CNT_W    = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_data,
  input  logic        m0_we,
  input  logic        m0_start,
  output logic [31:0] m0_q,
  output logic        m0_done,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_data,
  input  logic        m1_we,
  input  logic        m1_start,
  output logic [31:0] m1_q,
  output logic        m1_done,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_data,
  output logic        bus_we,
  output logic        bus_start,
  input  logic [31:0] bus_q,
  input  logic        bus_done,
  input  logic        bus_ready,
  output logic        owner,
  output logic        bus_timeout
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam bit               WDOG_EN  = (TIMEOUT != 0);

  state_t           state_q, state_d;
  logic [1:0]       pending_q, pending_d;
  logic [31:0]      req_addr_q [2];
  logic [31:0]      req_data_q [2];
  logic [1:0]       req_we_q;
  logic             rr_q, owner_q;
  logic [31:0]      bus_addr_q, bus_data_q, q0_q, q1_q;
  logic             bus_we_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [1:0]  start_v, accept, clear;
  logic        grant, winner, done_ok, expire, finish;
  logic [31:0] fin_q;

  assign start_v = {m1_start, m0_start};
  assign grant   = (state_q == IDLE) && (pending_q != 2'b00) && bus_ready;
  assign done_ok = (state_q == WAIT) && bus_done;
  assign expire  = WDOG_EN && (state_q == WAIT) && !bus_done && (cnt_q == CNT_LAST);
  assign finish  = done_ok || expire;
  assign fin_q   = done_ok ? bus_q : 32'h0;

  // A completing port may re-arm in its own done cycle: the set term wins over the clear.
  assign clear     = finish ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign accept    = start_v & (~pending_q | clear);
  assign pending_d = accept | (pending_q & ~clear);

  always_comb begin
    if ((PRIORITY == 0) && (pending_q == 2'b11)) winner = rr_q;
    else                                         winner = ~pending_q[0];
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ISSUE)     cnt_d = '0;
    else if (state_q == WAIT) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (finish) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus_start   = (state_q == ISSUE);
    owner       = (state_q != IDLE) && owner_q;
    m0_done     = finish && !owner_q;
    m1_done     = finish && owner_q;
    m0_q        = m0_done ? fin_q : q0_q;
    m1_q        = m1_done ? fin_q : q1_q;
    bus_timeout = expire;
  end

  assign bus_addr = bus_addr_q;
  assign bus_data = bus_data_q;
  assign bus_we   = bus_we_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_q     <= 2'b00;
      req_addr_q[0] <= '0;
      req_addr_q[1] <= '0;
      req_data_q[0] <= '0;
      req_data_q[1] <= '0;
      req_we_q      <= 2'b00;
      rr_q          <= 1'b0;
      owner_q       <= 1'b0;
      bus_addr_q    <= '0;
      bus_data_q    <= '0;
      bus_we_q      <= 1'b0;
      q0_q          <= '0;
      q1_q          <= '0;
      cnt_q         <= '0;
    end else begin
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      if (accept[0]) begin
        req_addr_q[0] <= m0_addr;
        req_data_q[0] <= m0_data;
        req_we_q[0]   <= m0_we;
      end
      if (accept[1]) begin
        req_addr_q[1] <= m1_addr;
        req_data_q[1] <= m1_data;
        req_we_q[1]   <= m1_we;
      end
      // Bus fields are frozen at grant so a re-armed request cannot disturb the live transaction.
      if (grant) begin
        owner_q    <= winner;
        bus_addr_q <= req_addr_q[winner];
        bus_data_q <= req_data_q[winner];
        bus_we_q   <= req_we_q[winner];
      end
      if (finish) begin
        rr_q <= ~owner_q;
        if (owner_q) q1_q <= fin_q;
        else         q0_q <= fin_q;
      end
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed self-checking bench for bus_arbiter
// A second instance with fixed priority shares the stimulus during the arbitration scenario.
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] m0_addr = '0, m0_data = '0, m1_addr = '0, m1_data = '0, bus_q = '0;
  logic        m0_we = 1'b0, m0_start = 1'b0, m1_we = 1'b0, m1_start = 1'b0;
  logic        bus_done = 1'b0, bus_ready = 1'b1;

  logic [31:0] m0_q, m1_q, bus_addr, bus_data;
  logic        m0_done, m1_done, bus_we, bus_start, owner, bus_timeout;
  logic [31:0] p_m0_q, p_m1_q, p_bus_addr, p_bus_data;
  logic        p_m0_done, p_m1_done, p_bus_we, p_bus_start, p_owner, p_bus_timeout;

  int errors = 0;
  int checks = 0;

  logic        cap_found, cap_owner, cap_we, cap_powner, cap_d0, cap_d1, cap_to;
  logic [31:0] cap_addr, cap_data, cap_paddr, cap_q0, cap_q1;

  bus_arbiter #(.PRIORITY(0), .TIMEOUT(8), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .m0_addr(m0_addr), .m0_data(m0_data), .m0_we(m0_we), .m0_start(m0_start),
    .m0_q(m0_q), .m0_done(m0_done),
    .m1_addr(m1_addr), .m1_data(m1_data), .m1_we(m1_we), .m1_start(m1_start),
    .m1_q(m1_q), .m1_done(m1_done),
    .bus_addr(bus_addr), .bus_data(bus_data), .bus_we(bus_we), .bus_start(bus_start),
    .bus_q(bus_q), .bus_done(bus_done), .bus_ready(bus_ready),
    .owner(owner), .bus_timeout(bus_timeout)
  );

  bus_arbiter #(.PRIORITY(1), .TIMEOUT(0), .CNT_W(16)) dut_p (
    .clk(clk), .reset(reset),
    .m0_addr(m0_addr), .m0_data(m0_data), .m0_we(m0_we), .m0_start(m0_start),
    .m0_q(p_m0_q), .m0_done(p_m0_done),
    .m1_addr(m1_addr), .m1_data(m1_data), .m1_we(m1_we), .m1_start(m1_start),
    .m1_q(p_m1_q), .m1_done(p_m1_done),
    .bus_addr(p_bus_addr), .bus_data(p_bus_data), .bus_we(p_bus_we), .bus_start(p_bus_start),
    .bus_q(bus_q), .bus_done(bus_done), .bus_ready(bus_ready),
    .owner(p_owner), .bus_timeout(p_bus_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL sim_timeout got=running exp=finished");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  // Waits (bounded) for the ISSUE cycle, records the bus fields, then completes the transaction lat cycles later.
  task automatic serve(input logic [31:0] q, input int lat);
    cap_found = 1'b0;
    for (int i = 0; i < 20 && !cap_found; i++) begin
      if (bus_start === 1'b1) cap_found = 1'b1;
      else tick();
    end
    if (cap_found) begin
      cap_owner = owner; cap_addr = bus_addr; cap_data = bus_data; cap_we = bus_we;
      cap_powner = p_owner; cap_paddr = p_bus_addr;
      repeat (lat) tick();
      bus_done = 1'b1;
      bus_q = q;
      #1;
      cap_d0 = m0_done; cap_d1 = m1_done; cap_q0 = m0_q; cap_q1 = m1_q; cap_to = bus_timeout;
      tick();
      bus_done = 1'b0;
      bus_q = '0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1 reset = 1'b0;
    tick();
    tick();
    checks++; if ({bus_start, bus_we, owner, m0_done, m1_done, bus_timeout} !== 6'b0) begin errors++; $display("FAIL rst_ctrl got=%b exp=000000", {bus_start, bus_we, owner, m0_done, m1_done, bus_timeout}); end
    checks++; if (bus_addr !== 32'h0 || bus_data !== 32'h0) begin errors++; $display("FAIL rst_bus got=%h/%h exp=0/0", bus_addr, bus_data); end
    checks++; if (m0_q !== 32'h0 || m1_q !== 32'h0) begin errors++; $display("FAIL rst_q got=%h/%h exp=0/0", m0_q, m1_q); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single_read();
    m0_addr = 32'h100; m0_we = 1'b0; m0_start = 1'b1;
    tick();
    m0_start = 1'b0;
    #1;
    checks++; if (bus_start !== 1'b0) begin errors++; $display("FAIL rd_early_start got=%b exp=0", bus_start); end
    tick();
    #1;
    checks++; if (bus_start !== 1'b1) begin errors++; $display("FAIL rd_start_n2 got=%b exp=1", bus_start); end
    checks++; if (bus_addr !== 32'h100 || bus_we !== 1'b0 || owner !== 1'b0) begin errors++; $display("FAIL rd_fields got=%h/%b/%b exp=100/0/0", bus_addr, bus_we, owner); end
    tick();
    tick();
    bus_done = 1'b1; bus_q = 32'hDEADBEEF;
    #1;
    checks++; if (m0_done !== 1'b1 || m0_q !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_done got=%b/%h exp=1/deadbeef", m0_done, m0_q); end
    checks++; if (m1_done !== 1'b0) begin errors++; $display("FAIL rd_m1_done got=%b exp=0", m1_done); end
    tick();
    bus_done = 1'b0; bus_q = 32'h12345678;
    #1;
    checks++; if (m0_done !== 1'b0 || m0_q !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_hold got=%b/%h exp=0/deadbeef", m0_done, m0_q); end
    checks++; if (m1_q !== 32'h0 || bus_start !== 1'b0) begin errors++; $display("FAIL rd_idle got=%h/%b exp=0/0", m1_q, bus_start); end
    bus_q = '0;
  endtask

  task automatic test_arbitration();
    do_reset();
    m0_addr = 32'h10; m0_data = 32'h55; m0_we = 1'b1; m0_start = 1'b1;
    m1_addr = 32'h20; m1_data = 32'h0;  m1_we = 1'b0; m1_start = 1'b1;
    tick();
    m0_start = 1'b0; m1_start = 1'b0;
    serve(32'h1111_0000, 1);
    checks++; if (cap_found !== 1'b1) begin errors++; $display("FAIL arb_a1_found got=%b exp=1", cap_found); end
    checks++; if (cap_owner !== 1'b0 || cap_addr !== 32'h10 || cap_we !== 1'b1 || cap_data !== 32'h55) begin errors++; $display("FAIL arb_a1_fields got=%b/%h/%b/%h exp=0/10/1/55", cap_owner, cap_addr, cap_we, cap_data); end
    checks++; if (cap_powner !== 1'b0 || cap_paddr !== 32'h10) begin errors++; $display("FAIL arb_a1_prio got=%b/%h exp=0/10", cap_powner, cap_paddr); end
    checks++; if (cap_d0 !== 1'b1 || cap_d1 !== 1'b0) begin errors++; $display("FAIL arb_a1_done got=%b%b exp=10", cap_d0, cap_d1); end
    serve(32'hA5A5_A5A5, 1);
    checks++; if (cap_found !== 1'b1 || cap_owner !== 1'b1 || cap_addr !== 32'h20 || cap_we !== 1'b0) begin errors++; $display("FAIL arb_a2_fields got=%b/%b/%h/%b exp=1/1/20/0", cap_found, cap_owner, cap_addr, cap_we); end
    checks++; if (cap_powner !== 1'b1) begin errors++; $display("FAIL arb_a2_prio got=%b exp=1", cap_powner); end
    checks++; if (cap_d1 !== 1'b1 || cap_d0 !== 1'b0 || cap_q1 !== 32'hA5A5_A5A5) begin errors++; $display("FAIL arb_a2_done got=%b%b/%h exp=01/a5a5a5a5", cap_d0, cap_d1, cap_q1); end
    m0_data = 32'h66; m0_start = 1'b1;
    tick();
    m0_start = 1'b0;
    serve(32'h2222_0000, 1);
    checks++; if (cap_found !== 1'b1 || cap_owner !== 1'b0) begin errors++; $display("FAIL arb_solo got=%b/%b exp=1/0", cap_found, cap_owner); end
    m0_data = 32'h55; m0_start = 1'b1; m1_start = 1'b1;
    tick();
    m0_start = 1'b0; m1_start = 1'b0;
    serve(32'h3333_0000, 1);
    checks++; if (cap_found !== 1'b1 || cap_owner !== 1'b1 || cap_addr !== 32'h20) begin errors++; $display("FAIL arb_b1_rr got=%b/%b/%h exp=1/1/20", cap_found, cap_owner, cap_addr); end
    checks++; if (cap_powner !== 1'b0 || cap_paddr !== 32'h10) begin errors++; $display("FAIL arb_b1_prio got=%b/%h exp=0/10", cap_powner, cap_paddr); end
    serve(32'h4444_0000, 1);
    checks++; if (cap_found !== 1'b1 || cap_owner !== 1'b0 || cap_powner !== 1'b1) begin errors++; $display("FAIL arb_b2 got=%b/%b/%b exp=1/0/1", cap_found, cap_owner, cap_powner); end
    checks++; if (cap_d0 !== 1'b1 || cap_q0 !== 32'h4444_0000) begin errors++; $display("FAIL arb_b2_done got=%b/%h exp=1/44440000", cap_d0, cap_q0); end
  endtask

  task automatic test_bus_ready();
    logic bad;
    bad = 1'b0;
    bus_ready = 1'b0;
    m1_addr = 32'h40; m1_we = 1'b0; m1_start = 1'b1;
    tick();
    m1_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (bus_start !== 1'b0) bad = 1'b1;
      tick();
    end
    bus_ready = 1'b1;
    #1;
    checks++; if (bad !== 1'b0 || bus_start !== 1'b0) begin errors++; $display("FAIL rdy_blocked got=%b/%b exp=0/0", bad, bus_start); end
    tick();
    #1;
    checks++; if (bus_start !== 1'b1 || owner !== 1'b1 || bus_addr !== 32'h40) begin errors++; $display("FAIL rdy_issue got=%b/%b/%h exp=1/1/40", bus_start, owner, bus_addr); end
    tick();
    bus_done = 1'b1; bus_q = 32'h77;
    #1;
    checks++; if (m1_done !== 1'b1 || m1_q !== 32'h77 || m0_done !== 1'b0) begin errors++; $display("FAIL rdy_done got=%b/%h/%b exp=1/77/0", m1_done, m1_q, m0_done); end
    tick();
    bus_done = 1'b0; bus_q = '0;
  endtask

  task automatic test_timeout();
    logic found, early;
    found = 1'b0;
    early = 1'b0;
    m0_addr = 32'h50; m0_we = 1'b0; m0_start = 1'b1;
    tick();
    m0_start = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (bus_start === 1'b1) found = 1'b1;
      else tick();
    end
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL to_issue got=%b exp=1", found); end
    for (int k = 1; k < 8; k++) begin
      tick();
      #1;
      if (m0_done !== 1'b0 || bus_timeout !== 1'b0 || bus_start !== 1'b0) early = 1'b1;
    end
    tick();
    #1;
    checks++; if (early !== 1'b0) begin errors++; $display("FAIL to_early got=%b exp=0", early); end
    checks++; if (m0_done !== 1'b1 || bus_timeout !== 1'b1 || m0_q !== 32'h0) begin errors++; $display("FAIL to_fire got=%b/%b/%h exp=1/1/0", m0_done, bus_timeout, m0_q); end
    checks++; if (m1_done !== 1'b0) begin errors++; $display("FAIL to_m1_done got=%b exp=0", m1_done); end
    tick();
    #1;
    checks++; if (bus_timeout !== 1'b0 || m0_done !== 1'b0 || m0_q !== 32'h0 || bus_start !== 1'b0) begin errors++; $display("FAIL to_after got=%b/%b/%h/%b exp=0/0/0/0", bus_timeout, m0_done, m0_q, bus_start); end
    m1_addr = 32'h60; m1_start = 1'b1;
    tick();
    m1_start = 1'b0;
    serve(32'h99, 2);
    checks++; if (cap_found !== 1'b1 || cap_owner !== 1'b1 || cap_addr !== 32'h60) begin errors++; $display("FAIL to_next_issue got=%b/%b/%h exp=1/1/60", cap_found, cap_owner, cap_addr); end
    checks++; if (cap_d1 !== 1'b1 || cap_q1 !== 32'h99 || cap_to !== 1'b0) begin errors++; $display("FAIL to_next_done got=%b/%h/%b exp=1/99/0", cap_d1, cap_q1, cap_to); end
  endtask

  task automatic test_duplicate_start();
    m0_addr = 32'h10; m0_data = 32'h1; m0_we = 1'b1; m0_start = 1'b1;
    tick();
    m0_addr = 32'h30; m0_data = 32'h2;
    tick();
    m0_start = 1'b0;
    #1;
    checks++; if (bus_start !== 1'b1 || bus_addr !== 32'h10 || bus_data !== 32'h1) begin errors++; $display("FAIL dup_kept got=%b/%h/%h exp=1/10/1", bus_start, bus_addr, bus_data); end
    tick();
    bus_done = 1'b1; bus_q = 32'h11;
    m0_addr = 32'h70; m0_we = 1'b0; m0_start = 1'b1;
    #1;
    checks++; if (m0_done !== 1'b1 || m0_q !== 32'h11) begin errors++; $display("FAIL dup_done got=%b/%h exp=1/11", m0_done, m0_q); end
    tick();
    bus_done = 1'b0; bus_q = '0; m0_start = 1'b0;
    #1;
    checks++; if (m0_done !== 1'b0 || bus_start !== 1'b0) begin errors++; $display("FAIL dup_single got=%b/%b exp=0/0", m0_done, bus_start); end
    serve(32'h22, 1);
    checks++; if (cap_found !== 1'b1 || cap_addr !== 32'h70 || cap_we !== 1'b0) begin errors++; $display("FAIL dup_rearm got=%b/%h/%b exp=1/70/0", cap_found, cap_addr, cap_we); end
    checks++; if (cap_d0 !== 1'b1 || cap_q0 !== 32'h22) begin errors++; $display("FAIL dup_rearm_done got=%b/%h exp=1/22", cap_d0, cap_q0); end
  endtask

  task automatic test_reset_during_wait();
    logic found, stray;
    found = 1'b0;
    stray = 1'b0;
    m0_addr = 32'h80; m0_start = 1'b1;
    m1_addr = 32'h90; m1_start = 1'b1;
    tick();
    m0_start = 1'b0; m1_start = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (bus_start === 1'b1) found = 1'b1;
      else tick();
    end
    tick();
    checks++; if (found !== 1'b1 || owner !== 1'b1 || bus_addr !== 32'h90) begin errors++; $display("FAIL rw_wait got=%b/%b/%h exp=1/1/90", found, owner, bus_addr); end
    reset = 1'b0;
    #1;
    checks++; if ({bus_start, owner, bus_we, m0_done, m1_done, bus_timeout} !== 6'b0) begin errors++; $display("FAIL rw_ctrl got=%b exp=000000", {bus_start, owner, bus_we, m0_done, m1_done, bus_timeout}); end
    checks++; if (bus_addr !== 32'h0 || m0_q !== 32'h0 || m1_q !== 32'h0) begin errors++; $display("FAIL rw_data got=%h/%h/%h exp=0/0/0", bus_addr, m0_q, m1_q); end
    tick();
    reset = 1'b1;
    bus_done = 1'b1; bus_q = 32'hBAD0BAD0;
    #1;
    checks++; if (m0_done !== 1'b0 || m1_done !== 1'b0 || m1_q !== 32'h0) begin errors++; $display("FAIL rw_stray got=%b/%b/%h exp=0/0/0", m0_done, m1_done, m1_q); end
    tick();
    bus_done = 1'b0; bus_q = '0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (bus_start !== 1'b0) stray = 1'b1;
      tick();
    end
    checks++; if (stray !== 1'b0) begin errors++; $display("FAIL rw_pending_lost got=%b exp=0", stray); end
    m0_addr = 32'hA0; m0_we = 1'b0; m0_start = 1'b1;
    tick();
    m0_start = 1'b0;
    serve(32'h33, 1);
    checks++; if (cap_found !== 1'b1 || cap_owner !== 1'b0 || cap_addr !== 32'hA0) begin errors++; $display("FAIL rw_new_issue got=%b/%b/%h exp=1/0/a0", cap_found, cap_owner, cap_addr); end
    checks++; if (cap_d0 !== 1'b1 || cap_q0 !== 32'h33) begin errors++; $display("FAIL rw_new_done got=%b/%h exp=1/33", cap_d0, cap_q0); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_arbitration();
    test_bus_ready();
    test_timeout();
    test_duplicate_start();
    test_reset_during_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Two-requester arbiter in front of the single CPU memory bus (start/done pulse protocol).
- Requester 0 is the data memory port; requester 1 is the instruction fetch port. Each presents the same interface the bus itself presents.
- Serialises requests, drives one bus transaction at a time, and returns done/q to the owning requester.
- Optional watchdog terminates transactions whose bus_done never arrives.

Parameters:
- PRIORITY, 0: 0 = round-robin between m0/m1; 1 = fixed priority, m0 always wins.
- TIMEOUT, 0: cycles in WAIT before forced completion; 0 disables the watchdog.
- CNT_W, 16: width of the watchdog counter. TIMEOUT must be < 2^CNT_W.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- reset  in  1  asynchronous, active-low reset.
- m0_addr  in  32  requester 0 address.
- m0_data  in  32  requester 0 write data.
- m0_we  in  1  requester 0 write enable.
- m0_start  in  1  requester 0 one-cycle start pulse.
- m0_q  out  32  requester 0 read data.
- m0_done  out  1  requester 0 completion pulse.
- m1_addr, m1_data, m1_we, m1_start, m1_q, m1_done: same as m0_* for requester 1.
- bus_addr  out  32  bus address.
- bus_data  out  32  bus write data.
- bus_we  out  1  bus write enable.
- bus_start  out  1  bus start pulse.
- bus_q  in  32  bus read data.
- bus_done  in  1  bus completion pulse.
- bus_ready  in  1  bus can accept a start.
- owner  out  1  requester currently granted; valid in ISSUE/WAIT.
- bus_timeout  out  1  one-cycle pulse on watchdog expiry.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, both pending flags=0, request registers=0, rr pointer=0.
  - All outputs 0, including m0_q/m1_q holding registers.
  - Any in-flight bus transaction is abandoned; a bus_done arriving after reset release is ignored because state is IDLE.
- Request capture:
  - mX_start=1 with pending[X]=0 latches mX_addr/data/we into that port's request register and sets pending[X] on the next edge.
  - mX_start while pending[X]=1 is ignored; the original request is kept.
  - If pending[X] is cleared by completion in the same cycle mX_start arrives, the new request is accepted (set wins).
- IDLE:
  - If any pending and bus_ready=1, select the winner and go to ISSUE on the next edge.
  - PRIORITY=1: m0 wins.
  - PRIORITY=0: if both are pending, the port equal to rr wins; otherwise the single pending port wins.
  - bus_ready=0: remain in IDLE; pending requests are held.
- ISSUE (exactly 1 cycle):
  - bus_start=1.
  - bus_addr/data/we = winner's request register; owner=winner.
  - Next state: WAIT; watchdog counter cleared.
- WAIT:
  - bus_addr/data/we/owner held stable; bus_start=0; counter increments each cycle.
  - On bus_done=1, the same cycle (combinational): m[owner]_done=1, m[owner]_q=bus_q.
  - On that edge: the q holding register loads bus_q, pending[owner] clears, rr becomes !owner, state returns to IDLE.
  - If TIMEOUT≠0 and counter reaches TIMEOUT without bus_done: m[owner]_done=1, m[owner]_q=0, bus_timeout=1 for one cycle. Same state updates as a normal done.
  - bus_done in IDLE or ISSUE is ignored.
- Outside its done cycle, mX_q = that port's last registered q. mX_done is never asserted for the non-owner.
- Minimum latency: mX_start at cycle N → bus_start at N+2 → mX_done in the bus_done cycle. Back-to-back grants: at least one IDLE cycle between transactions.
- In IDLE, bus_addr/data/we keep the last transaction's values (0 after reset).

Test Plan:
- Single read on m0 (addr=0x100), bus returns 0xDEADBEEF two cycles after bus_start → bus_start at N+2, addr=0x100, we=0; m0_done with m0_q=0xDEADBEEF; m0_q holds afterwards; m1_done stays 0.
- Simultaneous m0 write (0x10, 0x55) and m1 read (0x20), PRIORITY=0, rr=0 → m0 is served first, then m1. A repeat of the simultaneous pair serves m1 first (rr=1). With PRIORITY=1, m0 is served first both times.
- bus_ready=0 for 5 cycles with m1 pending → no bus_start; bus_start issues the cycle after bus_ready rises; pending is retained.
- TIMEOUT=8, bus never signals done → exactly 8 WAIT cycles, then m0_done=1, m0_q=0, bus_timeout=1 pulse; arbiter back in IDLE and serves the next request normally.
- m0_start pulsed again while m0 is pending (addr 0x30 vs original 0x10) → bus_addr=0x10 only; a single m0_done. A start in the m0 done cycle is accepted and issued.
- reset low during WAIT with m1 pending → all outputs 0 immediately. A stray bus_done after release produces no mX_done. The first new request issues cleanly.
